input_frame_buffer: RTL and testbench

//  Downstream of the 64-point input counter. Captures one frame of 64 complex samples, writing each at the
//  bit-reversed sample index, and streams the frame to the FFT butterfly stage with a valid/ready handshake.

---
 rtl/input_frame_buffer.sv | 190 +++++++++++++++++++
 tb/tb_input_frame_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_frame_buffer.sv
// input_frame_buffer: captures 64-sample complex frames at bit-reversed
// addresses into two ping-pong banks and streams each completed bank out
// in natural order over a valid/ready handshake.
module input_frame_buffer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_re,
    input  logic [DATA_W-1:0] din_im,
    input  logic              din_valid,
    input  logic [5:0]        counter_i,
    input  logic              mastertrig,
    output logic [DATA_W-1:0] dout_re,
    output logic [DATA_W-1:0] dout_im,
    output logic [5:0]        dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              frame_rdy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_DRAIN
    } rd_state_t;

    localparam int WORD_W = 2 * DATA_W;

    // Two banks of 64 words; the bank number is the top address bit.
    logic [WORD_W-1:0] mem [0:127];

    logic [1:0]  full;
    logic [1:0]  full_next;
    logic        wr_bank;
    logic        rd_bank;
    logic        armed;
    logic        dropping;
    logic [5:0]  rd_addr;
    rd_state_t   state;
    rd_state_t   state_next;
    logic        load;
    logic        release_bank;
    logic        wr_free;
    logic        frame_end;
    logic        accept;
    logic        drop;
    logic [WORD_W-1:0] rd_word;

    function automatic logic [5:0] bitrev6(input logic [5:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i] = v[5-i];
        end
        return r;
    endfunction

    // The write bank may take samples when it is empty, or when its previous
    // frame has already been moved into the output register and is handed
    // off this very cycle. A frame that lost any sample is never accepted.
    assign wr_free   = !full[wr_bank] || (release_bank && (rd_bank == wr_bank));
    assign frame_end = din_valid && (counter_i == 6'd63) && armed;
    assign accept    = frame_end && wr_free && !dropping;
    assign drop      = frame_end && !accept;
    assign rd_word   = mem[{rd_bank, rd_addr}];

    // Sample storage, written at the bit-reversed index of the current bank.
    // NOTE: the sample memory has no reset; its contents are only observed
    // after a whole frame has been written, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (din_valid && wr_free) begin
            mem[{wr_bank, bitrev6(counter_i)}] <= {din_re, din_im};
        end
    end

    // Bank occupancy: set by an accepted frame, cleared by the final handoff.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        full_next = full;
        if (release_bank) begin
            full_next[rd_bank] = 1'b0;
        end
        if (accept) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    // Write-side control: arming, frame acceptance, drop tracking, overflow.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            armed     <= 1'b0;
            dropping  <= 1'b0;
            overflow  <= 1'b0;
            frame_rdy <= 1'b0;
        end else begin
            full      <= full_next;
            frame_rdy <= full[0] | full[1];
            overflow  <= drop;
            if (accept) begin
                wr_bank <= ~wr_bank;
            end
            if (frame_end) begin
                armed <= 1'b0;
            end else if (mastertrig) begin
                armed <= 1'b1;
            end
            if (din_valid && (counter_i == 6'd63)) begin
                dropping <= 1'b0;
            end else if (din_valid && !wr_free) begin
                dropping <= 1'b1;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state: load whenever the output register is free.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        release_bank = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    state_next = RD_LOAD;
                end
            end
            RD_LOAD: begin
                if (!dout_valid || dout_ready) begin
                    load = 1'b1;
                    if (rd_addr == 6'd63) begin
                        state_next = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (dout_valid && dout_ready) begin
                    release_bank = 1'b1;
                    state_next   = RD_IDLE;
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    // Read address, bank pointer and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr    <= 6'd0;
            rd_bank    <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            dout_addr  <= 6'd0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            if (state == RD_IDLE) begin
                rd_addr <= 6'd0;
            end else if (load) begin
                rd_addr <= rd_addr + 6'd1;
            end
            if (load) begin
                {dout_re, dout_im} <= rd_word;
                dout_addr          <= rd_addr;
                dout_last          <= (rd_addr == 6'd63);
                dout_valid         <= 1'b1;
            end else if (release_bank) begin
                dout_valid <= 1'b0;
            end
            if (release_bank) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_input_frame_buffer.sv
// Bench for input_frame_buffer: directed scenarios with random sample data,
// scored against a frame-level model (pending-frame count plus a queue of
// expected output words).
module tb_input_frame_buffer;

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } word_t;

    logic        clk;
    logic        rst;
    logic [15:0] din_re;
    logic [15:0] din_im;
    logic        din_valid;
    logic [5:0]  counter_i;
    logic        mastertrig;
    logic [15:0] dout_re;
    logic [15:0] dout_im;
    logic [5:0]  dout_addr;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        frame_rdy;
    logic        overflow;

    input_frame_buffer #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_re     (din_re),
        .din_im     (din_im),
        .din_valid  (din_valid),
        .counter_i  (counter_i),
        .mastertrig (mastertrig),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .frame_rdy  (frame_rdy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int    checks   = 0;
    int    failures = 0;
    string phase    = "reset";

    // Reference model state.
    logic [31:0] cur [64];     // current frame, indexed by input sample index
    word_t       sb [$];       // expected output words, in order
    int          pending;      // accepted frames not yet fully handed off
    bit          armed;
    bit          bad;          // current frame lost a sample
    bit          prev_stall;
    word_t       held;
    bit          hs_last;
    int          ovf_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s_%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < 6; i++) begin
            r = r * 2 + ((v >> i) & 1);
        end
        return r;
    endfunction

    task automatic model_reset();
        pending    = 0;
        armed      = 0;
        bad        = 0;
        prev_stall = 0;
        hs_last    = 0;
        sb.delete();
    endtask

    task automatic drive(input logic v, input int idx, input logic mt,
                         input logic [15:0] re, input logic [15:0] im);
        din_valid  = v;
        counter_i  = 6'(idx);
        mastertrig = mt;
        din_re     = re;
        din_im     = im;
    endtask

    // One clock: score outputs just before the edge, advance the model with
    // the inputs the DUT sees at that edge, then check the overflow pulse.
    task automatic step();
        bit    hs;
        bit    releasing;
        bit    accepted;
        bit    completed;
        bit    exp_ovf;
        word_t obs;
        word_t e;
        @(negedge clk);
        obs = {dout_addr, dout_re, dout_im, dout_last};
        if (prev_stall) begin
            check("hold", 64'({dout_valid, obs}), 64'({1'b1, held}));
        end
        hs         = dout_valid && dout_ready;
        prev_stall = dout_valid && !dout_ready;
        held       = obs;
        releasing  = 0;
        accepted   = 0;
        completed  = 0;
        exp_ovf    = 0;
        hs_last    = 0;
        if (hs) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                check("data", 64'(obs), 64'(e));
                releasing = e.last;
                hs_last   = dout_last;
            end
        end
        if (din_valid) begin
            if ((pending == 2) && !releasing) bad = 1;
            else cur[counter_i] = {din_re, din_im};
            if (counter_i == 6'd63) begin
                if (armed) begin
                    completed = 1;
                    if (bad) begin
                        exp_ovf = 1;
                    end else begin
                        accepted = 1;
                        for (int k = 0; k < 64; k++) begin
                            e.addr = 6'(k);
                            {e.re, e.im} = cur[bitrev(k)];
                            e.last = (k == 63);
                            sb.push_back(e);
                        end
                    end
                end
                bad = 0;
            end
        end
        if (completed) armed = 0;
        else if (mastertrig) armed = 1;
        pending = pending - int'(releasing) + int'(accepted);
        @(posedge clk);
        #1;
        check("overflow", 64'(overflow), 64'(exp_ovf));
        if (overflow) ovf_seen++;
    endtask

    task automatic send_frame(input bit arm, input bit rnd);
        for (int i = 0; i < 64; i++) begin
            if (rnd) drive(1'b1, i, arm && (i == 54), 16'($urandom), 16'($urandom));
            else     drive(1'b1, i, arm && (i == 54), 16'(i), 16'(-i));
            step();
        end
        drive(1'b0, 0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic drain(input int budget, input bit toggle);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            if (toggle) dout_ready = ~dout_ready;
            step();
            n++;
        end
        check("drain_left", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int n;
        rst = 1'b0;
        dout_ready = 1'b0;
        drive(1'b0, 0, 1'b0, 16'd0, 16'd0);
        model_reset();
        ovf_seen = 0;
        @(posedge clk);
        #1;
        check("outputs", 64'({dout_re, dout_im, dout_addr, dout_valid, dout_last, frame_rdy, overflow}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: ramp frame, free-running ready, latency and no-bubble drain.
        phase = "t1";
        dout_ready = 1'b1;
        send_frame(1'b1, 1'b0);
        step();
        check("latency_gap", 64'(dout_valid), 64'(0));
        step();
        check("first_valid", 64'({dout_valid, frame_rdy, dout_addr}), 64'({1'b1, 1'b1, 6'd0}));
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_cycles", 64'(n), 64'(64));
        step();
        step();
        check("idle_after", 64'({dout_valid, frame_rdy}), 64'(0));

        // 2: random frame, ready toggling every cycle during drain.
        phase = "t2";
        dout_ready = 1'b0;
        send_frame(1'b1, 1'b1);
        n = 0;
        while (!dout_valid && n < 10) begin
            step();
            n++;
        end
        check("valid_seen", 64'(dout_valid), 64'(1));
        dout_ready = 1'b0;
        drain(300, 1'b1);
        dout_ready = 1'b1;
        repeat (3) step();

        // 3: three back-to-back frames with ready low; third is dropped.
        phase = "t3";
        dout_ready = 1'b0;
        ovf_seen = 0;
        send_frame(1'b1, 1'b1);
        send_frame(1'b1, 1'b1);
        send_frame(1'b1, 1'b1);
        step();
        check("ovf_count", 64'(ovf_seen), 64'(1));
        check("frame_rdy", 64'(frame_rdy), 64'(1));
        dout_ready = 1'b1;
        drain(400, 1'b0);
        repeat (3) step();
        check("empty", 64'({dout_valid, frame_rdy}), 64'(0));

        // 4: next frame completes on the cycle the previous frame's last word is taken.
        phase = "t4";
        dout_ready = 1'b1;
        ovf_seen = 0;
        send_frame(1'b1, 1'b1);
        step();
        step();
        send_frame(1'b1, 1'b1);
        check("coincide", 64'(hs_last), 64'(1));
        drain(200, 1'b0);
        check("no_ovf", 64'(ovf_seen), 64'(0));
        repeat (3) step();

        // 5: reset in the middle of an armed frame, then a partial tail.
        phase = "t5";
        ovf_seen = 0;
        for (int i = 0; i <= 30; i++) begin
            drive(1'b1, i, i == 20, 16'($urandom), 16'($urandom));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 0, 1'b0, 16'd0, 16'd0);
        #2;
        check("reset_outputs", 64'({dout_valid, frame_rdy, overflow}), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 40; i < 64; i++) begin
            drive(1'b1, i, 1'b0, 16'($urandom), 16'($urandom));
            step();
        end
        drive(1'b0, 0, 1'b0, 16'd0, 16'd0);
        repeat (4) step();
        check("quiet", 64'({dout_valid, frame_rdy}), 64'(0));
        check("no_ovf", 64'(ovf_seen), 64'(0));

        // 6: a full frame without mastertrig is never accepted.
        phase = "t6";
        send_frame(1'b0, 1'b1);
        repeat (4) step();
        check("quiet", 64'({dout_valid, frame_rdy}), 64'(0));
        check("no_expected", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
